// File: rtl/image_scaler_engine_if.sv
// Handshake and frame-memory bus of the image scaler engine.
// master: engine side; slave: controller plus source ROM and destination RAM side.
interface image_scaler_engine_if #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned RADDR_W = 15,
  parameter int unsigned WADDR_W = 19
);
  logic               start;
  logic [1:0]         mode;
  logic [1:0]         factor_log2;
  logic [RADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]   rd_data;
  logic               wr_en;
  logic [WADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]   wr_data;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    input  start, mode, factor_log2, rd_data,
    output rd_addr, wr_en, wr_addr, wr_data, busy, done, cfg_err
  );

  modport slave (
    output start, mode, factor_log2, rd_data,
    input  rd_addr, wr_en, wr_addr, wr_data, busy, done, cfg_err
  );
endinterface

// File: rtl/image_scaler_engine.sv
// Replicate / decimate / block-average scaler by 2^k between a frame ROM and a frame RAM.
// Define AVG_ROUND_EN to round block averages half up instead of truncating.
module image_scaler_engine #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned SRC_W     = 160,
  parameter int unsigned SRC_H     = 120,
  parameter int unsigned MAX_LOG2F = 2,
  parameter int unsigned RADDR_W   = 15,
  parameter int unsigned WADDR_W   = 19
) (
  input logic                  clk,
  input logic                  rst_n,
  image_scaler_engine_if.master bus
);
  localparam int unsigned ACC_W = PIX_W + 2 * MAX_LOG2F;
  localparam int unsigned X_W   = $clog2((SRC_W << MAX_LOG2F) + 1);
  localparam int unsigned Y_W   = $clog2((SRC_H << MAX_LOG2F) + 1);
  localparam int unsigned D_W   = (MAX_LOG2F > 0) ? MAX_LOG2F : 1;
  localparam logic [1:0]  MAX_K = 2'(MAX_LOG2F);

  localparam logic [1:0] ModeRep = 2'b00;
  localparam logic [1:0] ModeAvg = 2'b10;
  localparam logic [1:0] ModeBad = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d, k_q, k_d;
  logic               err_q, err_d, flush_q, flush_d;
  logic [X_W-1:0]     ox_q, ox_d;
  logic [Y_W-1:0]     oy_q, oy_d;
  logic [D_W-1:0]     dx_q, dx_d, dy_q, dy_d;
  logic               vld1_q, first1_q, last1_q;
  logic [ACC_W-1:0]   acc_q, sum, sum_r;
  logic               wr_en_q;
  logic [WADDR_W-1:0] wr_addr_q, wr_cnt_q;
  logic [PIX_W-1:0]   wr_data_q;
  logic [31:0]        out_w, out_h, fm1, row, col, raddr;
  logic               is_avg, blk_end, job_end;
  logic [2:0]         shamt;

  // Geometry of the read currently presented on rd_addr.
  always_comb begin
    is_avg = (mode_q == ModeAvg);
    fm1    = (32'd1 << k_q) - 32'd1;
    if (mode_q == ModeRep) begin
      out_w = 32'(SRC_W) << k_q;
      out_h = 32'(SRC_H) << k_q;
      row   = 32'(oy_q) >> k_q;
      col   = 32'(ox_q) >> k_q;
    end else begin
      out_w = 32'(SRC_W) >> k_q;
      out_h = 32'(SRC_H) >> k_q;
      row   = (32'(oy_q) << k_q) + 32'(dy_q);
      col   = (32'(ox_q) << k_q) + 32'(dx_q);
    end
    raddr   = row * 32'(SRC_W) + col;
    blk_end = !is_avg || ((32'(dx_q) == fm1) && (32'(dy_q) == fm1));
    job_end = blk_end && (32'(ox_q) == out_w - 32'd1) && (32'(oy_q) == out_h - 32'd1);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    k_d     = k_q;
    err_d   = err_q;
    flush_d = flush_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d = bus.mode;
          k_d    = (bus.factor_log2 > MAX_K) ? MAX_K : bus.factor_log2;
          ox_d   = '0;
          oy_d   = '0;
          dx_d   = '0;
          dy_d   = '0;
          err_d  = (bus.mode == ModeBad);
          state_d = (bus.mode == ModeBad) ? StDone : StRun;
        end
      end
      StRun: begin
        if (job_end) begin
          state_d = StFlush;
          flush_d = 1'b0;
        end else if (is_avg && (32'(dx_q) != fm1)) begin
          dx_d = dx_q + D_W'(1);
        end else if (is_avg && (32'(dy_q) != fm1)) begin
          dx_d = '0;
          dy_d = dy_q + D_W'(1);
        end else begin
          dx_d = '0;
          dy_d = '0;
          if (32'(ox_q) == out_w - 32'd1) begin
            ox_d = '0;
            oy_d = oy_q + Y_W'(1);
          end else begin
            ox_d = ox_q + X_W'(1);
          end
        end
      end
      StFlush: begin
        flush_d = 1'b1;
        if (flush_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Block sum; the first sample of a block loads rather than accumulates.
  always_comb begin
    sum   = first1_q ? ACC_W'(bus.rd_data) : acc_q + ACC_W'(bus.rd_data);
    shamt = is_avg ? {k_q, 1'b0} : 3'd0;
`ifdef AVG_ROUND_EN
    sum_r = (shamt != 3'd0) ? sum + (ACC_W'(1) << (shamt - 3'd1)) : sum;
`else
    sum_r = sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      err_q   <= err_d;
      flush_q <= flush_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q    <= 1'b0;
      first1_q  <= 1'b0;
      last1_q   <= 1'b0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      vld1_q   <= (state_q == StRun);
      first1_q <= (dx_q == '0) && (dy_q == '0);
      last1_q  <= blk_end;
      wr_en_q  <= vld1_q && last1_q;
      if (vld1_q) acc_q <= sum;
      if (vld1_q && last1_q) begin
        wr_data_q <= PIX_W'(sum_r >> shamt);
        wr_addr_q <= wr_cnt_q;
        wr_cnt_q  <= wr_cnt_q + WADDR_W'(1);
      end else if (state_q == StIdle && bus.start) begin
        wr_cnt_q <= '0;
      end
    end
  end

  assign bus.rd_addr = (state_q == StRun) ? RADDR_W'(raddr) : '0;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q == StRun) || (state_q == StFlush);
  assign bus.done    = (state_q == StDone);
  assign bus.cfg_err = (state_q == StDone) && err_q;
endmodule
